rf_wb_merge: RTL and testbench

Writeback merge unit for the dual-issue core. It accepts up to two retiring results per cycle (lane 0 older than lane 1) over valid/ready handshakes and buffers them in a small in-order FIFO. It drains them one per cycle into the register file's single write port (write enable / write address / write data). It also provides forwarding lookups so decode reads can see results that are still pending.

---
 rtl/rf_wb_merge.sv | 191 +++++++++++++++++++
 tb/tb_rf_wb_merge.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_merge.sv
// Writeback merge: two retiring lanes -> in-order FIFO -> single RF write port, with forwarding lookup.
// Optional macro RF_WB_FWD_EN builds the forwarding comparators; otherwise q*_hit/q*_data are tied to 0.
module rf_wb_merge #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [4:0]        in0_rd,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [4:0]        in1_rd,
  input  logic [DATA_W-1:0] in1_data,
  output logic              rf_we,
  output logic [4:0]        rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  input  logic [4:0]        q0_addr,
  input  logic [4:0]        q1_addr,
  output logic              q0_hit,
  output logic              q1_hit,
  output logic [DATA_W-1:0] q0_data,
  output logic [DATA_W-1:0] q1_data,
  output logic [CNT_W-1:0]  pend_cnt,
  output logic              idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAST_FREE = CNT_W'(DEPTH - 1);

  logic [4:0]        mem_rd_q   [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rf_we_q, load_d;
  logic [4:0]        rf_wa_q, ld_rd;
  logic [DATA_W-1:0] rf_wd_q, ld_data;
  logic              in0_ready_q, in1_ready_q, in1_ready_d;
  logic              idle_q, idle_d;

  logic              acc0, acc1, pop;
  logic [1:0]        enq_n;
  logic [4:0]        ea_rd, eb_rd;
  logic [DATA_W-1:0] ea_data, eb_data;
  logic [CNT_W:0]    sum;

  assign in0_ready = in0_ready_q;
  assign in1_ready = in1_ready_q;
  assign rf_we     = rf_we_q;
  assign rf_wa     = rf_wa_q;
  assign rf_wd     = rf_wd_q;
  assign pend_cnt  = count_q;
  assign idle      = idle_q;

  always_comb begin
    acc0    = in0_valid && in0_ready_q && (in0_rd != 5'd0);
    acc1    = in1_valid && in1_ready_q && (in1_rd != 5'd0);
    pop     = (count_q != '0);
    load_d  = 1'b0;
    ld_rd   = '0;
    ld_data = '0;
    enq_n   = 2'd0;
    ea_rd   = '0;
    ea_data = '0;
    eb_rd   = '0;
    eb_data = '0;
    // Oldest of {head, lane 0, lane 1} goes to the output register; the rest enqueue in order.
    if (pop) begin
      load_d  = 1'b1;
      ld_rd   = mem_rd_q[head_q];
      ld_data = mem_data_q[head_q];
      if (acc0) begin
        ea_rd   = in0_rd;
        ea_data = in0_data;
        enq_n   = 2'd1;
        if (acc1) begin
          eb_rd   = in1_rd;
          eb_data = in1_data;
          enq_n   = 2'd2;
        end
      end else if (acc1) begin
        ea_rd   = in1_rd;
        ea_data = in1_data;
        enq_n   = 2'd1;
      end
    end else if (acc0) begin
      load_d  = 1'b1;
      ld_rd   = in0_rd;
      ld_data = in0_data;
      if (acc1) begin
        ea_rd   = in1_rd;
        ea_data = in1_data;
        enq_n   = 2'd1;
      end
    end else if (acc1) begin
      load_d  = 1'b1;
      ld_rd   = in1_rd;
      ld_data = in1_data;
    end
    sum         = {1'b0, count_q} + (CNT_W+1)'(acc0) + (CNT_W+1)'(acc1);
    count_d     = (sum != '0) ? CNT_W'(sum - (CNT_W+1)'(1)) : CNT_W'(sum);
    in1_ready_d = (count_d <= LAST_FREE);
    idle_d      = (count_d == '0) && !load_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rf_we_q     <= 1'b0;
      rf_wa_q     <= '0;
      rf_wd_q     <= '0;
      in0_ready_q <= 1'b0;
      in1_ready_q <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      head_q      <= head_q + PTR_W'(pop);
      tail_q      <= tail_q + PTR_W'(enq_n);
      count_q     <= count_d;
      rf_we_q     <= load_d;
      in0_ready_q <= 1'b1;
      in1_ready_q <= in1_ready_d;
      idle_q      <= idle_d;
      if (load_d) begin
        rf_wa_q <= ld_rd;
        rf_wd_q <= ld_data;
      end
    end
  end

  // Storage needs no reset: entries are only read below the occupancy count.
  always_ff @(posedge clk) begin
    if (enq_n != 2'd0) begin
      mem_rd_q[tail_q]   <= ea_rd;
      mem_data_q[tail_q] <= ea_data;
    end
    if (enq_n == 2'd2) begin
      mem_rd_q[tail_q + PTR_W'(1)]   <= eb_rd;
      mem_data_q[tail_q + PTR_W'(1)] <= eb_data;
    end
  end

`ifdef RF_WB_FWD_EN
  logic [4:0]        qa    [2];
  logic              qhit  [2];
  logic [DATA_W-1:0] qdata [2];
  logic [PTR_W-1:0]  idx;

  assign qa[0] = q0_addr;
  assign qa[1] = q1_addr;

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    idx = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      qhit[p]  = 1'b0;
      qdata[p] = '0;
      if (qa[p] != 5'd0) begin
        if (rf_we_q && (rf_wa_q == qa[p])) begin
          qhit[p]  = 1'b1;
          qdata[p] = rf_wd_q;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
          idx = head_q + PTR_W'(i);
          if ((CNT_W'(i) < count_q) && (mem_rd_q[idx] == qa[p])) begin
            qhit[p]  = 1'b1;
            qdata[p] = mem_data_q[idx];
          end
        end
      end
    end
  end

  assign q0_hit  = qhit[0];
  assign q1_hit  = qhit[1];
  assign q0_data = qdata[0];
  assign q1_data = qdata[1];
`else
  logic unused_qaddr;
  assign unused_qaddr = ^{q0_addr, q1_addr};
  assign q0_hit  = 1'b0;
  assign q1_hit  = 1'b0;
  assign q0_data = '0;
  assign q1_data = '0;
`endif

endmodule

// File: tb/tb_rf_wb_merge.sv
// Randomized + directed bench for rf_wb_merge against a queue-based model of pending writes.
module tb_rf_wb_merge;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 3;
`ifdef RF_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk, rst_n;
  logic              in0_valid, in0_ready, in1_valid, in1_ready;
  logic [4:0]        in0_rd, in1_rd;
  logic [DATA_W-1:0] in0_data, in1_data;
  logic              rf_we;
  logic [4:0]        rf_wa;
  logic [DATA_W-1:0] rf_wd;
  logic [4:0]        q0_addr, q1_addr;
  logic              q0_hit, q1_hit;
  logic [DATA_W-1:0] q0_data, q1_data;
  logic [CNT_W-1:0]  pend_cnt;
  logic              idle;

  rf_wb_merge #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_rd(in0_rd), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_rd(in1_rd), .in1_data(in1_data),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .q0_addr(q0_addr), .q1_addr(q1_addr),
    .q0_hit(q0_hit), .q1_hit(q1_hit), .q0_data(q0_data), .q1_data(q1_data),
    .pend_cnt(pend_cnt), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } item_t;

  // Model: items not yet presented to the RF port, plus the item currently on it.
  item_t             pend[$];
  logic              m_we;
  logic [4:0]        m_wa;
  logic [DATA_W-1:0] m_wd;
  logic              m_r0, m_r1;
  logic [DATA_W-1:0] rf [32];
  int unsigned       wr_log[$];
  int unsigned       n_checks, n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_we = 1'b0; m_wa = '0; m_wd = '0;
    m_r0 = 1'b0; m_r1 = 1'b0;
  endtask

  task automatic model_step();
    item_t items[$];
    item_t t;
    items = pend;
    if (in0_valid && m_r0 && in0_rd != 5'd0) begin
      t.rd = in0_rd; t.data = in0_data; items.push_back(t);
    end
    if (in1_valid && m_r1 && in1_rd != 5'd0) begin
      t.rd = in1_rd; t.data = in1_data; items.push_back(t);
    end
    if (items.size() > 0) begin
      t = items.pop_front();
      m_we = 1'b1; m_wa = t.rd; m_wd = t.data;
    end else begin
      m_we = 1'b0;
    end
    pend = items;
    m_r0 = 1'b1;
    m_r1 = (pend.size() <= DEPTH - 1);
  endtask

  task automatic fwd(input logic [4:0] a, output logic h, output logic [DATA_W-1:0] d);
    h = 1'b0; d = '0;
    if (FWD && a != 5'd0) begin
      if (m_we && m_wa == a) begin h = 1'b1; d = m_wd; end
      foreach (pend[i]) if (pend[i].rd == a) begin h = 1'b1; d = pend[i].data; end
    end
  endtask

  task automatic compare_all();
    logic              h;
    logic [DATA_W-1:0] d;
    check("rf_we", rf_we, m_we);
    check("rf_wa", rf_wa, m_wa);
    check("rf_wd", rf_wd, m_wd);
    check("in0_ready", in0_ready, m_r0);
    check("in1_ready", in1_ready, m_r1);
    check("pend_cnt", pend_cnt, pend.size());
    check("idle", idle, (pend.size() == 0) && !m_we);
    fwd(q0_addr, h, d);
    check("q0_hit", q0_hit, h);
    check("q0_data", q0_data, d);
    fwd(q1_addr, h, d);
    check("q1_hit", q1_hit, h);
    check("q1_data", q1_data, d);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare_all();
    if (rf_we) begin
      rf[rf_wa] = rf_wd;
      wr_log.push_back(int'(rf_wa));
    end
  endtask

  task automatic quiet();
    in0_valid = 1'b0; in1_valid = 1'b0;
  endtask

  task automatic lanes(input logic v0, input logic [4:0] r0, input logic [DATA_W-1:0] d0,
                       input logic v1, input logic [4:0] r1, input logic [DATA_W-1:0] d1);
    in0_valid = v0; in0_rd = r0; in0_data = d0;
    in1_valid = v1; in1_rd = r1; in1_data = d1;
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    foreach (rf[i]) rf[i] = '0;
    rst_n = 1'b0; q0_addr = '0; q1_addr = '0;
    lanes(1'b0, '0, '0, 1'b0, '0, '0);
    model_reset();
    #7 compare_all();
    cycle();
    rst_n = 1'b1;
    cycle();

    // Single lane 0 write
    lanes(1'b1, 5'd5, 32'h1FD961AB, 1'b0, '0, '0);
    q0_addr = 5'd5;
    cycle();
    quiet();
    repeat (3) cycle();
    check("rf_x5", rf[5], 32'h1FD961AB);

    // Four cycles of dual-issue x1..x8
    wr_log.delete();
    for (int k = 0; k < 4; k++) begin
      lanes(1'b1, 5'(2*k+1), 32'h100 + 32'(2*k+1), 1'b1, 5'(2*k+2), 32'h100 + 32'(2*k+2));
      q1_addr = 5'(2*k+1);
      cycle();
    end
    check("full_cnt", pend_cnt, DEPTH);
    check("full_in1_ready", in1_ready, 1'b0);
    quiet();
    repeat (10) cycle();
    check("drain_len", wr_log.size(), 8);
    for (int k = 0; k < 8 && k < wr_log.size(); k++) check("drain_order", wr_log[k], k + 1);

    // x0 on both lanes is accepted and dropped
    lanes(1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 32'hDEADBEEF);
    q0_addr = 5'd0;
    cycle();
    quiet();
    cycle();
    check("x0_cnt", pend_cnt, 0);

    // Same-register collision, lane 1 wins
    lanes(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
    q0_addr = 5'd3;
    cycle();
    quiet();
    repeat (3) cycle();
    check("rf_x3", rf[3], 32'h22);

    // Fill, then reset mid-stream; lane 0 held valid across release
    for (int k = 0; k < 4; k++) begin
      lanes(1'b1, 5'(10+k), 32'hA000 + 32'(k), 1'b1, 5'(20+k), 32'hB000 + 32'(k));
      cycle();
    end
    async_reset();
    check("rst_we", rf_we, 1'b0);
    check("rst_cnt", pend_cnt, 0);
    repeat (2) cycle();
    lanes(1'b1, 5'd7, 32'h77, 1'b0, '0, '0);
    rst_n = 1'b1;
    cycle();
    quiet();
    repeat (2) cycle();

    // Random traffic with one async reset in the middle
    for (int k = 0; k < 600; k++) begin
      lanes(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom(),
            ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom());
      if ($urandom_range(0, 15) == 0) in0_rd = 5'($urandom_range(8, 31));
      q0_addr = 5'($urandom_range(0, 7));
      q1_addr = 5'($urandom_range(0, 7));
      if (k == 300) begin
        async_reset();
        cycle();
        rst_n = 1'b1;
      end
      cycle();
    end
    quiet();
    repeat (10) cycle();
    check("final_idle", idle, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
